// File: rtl/mem_if_pkg.sv
// Shared types and encodings for the AHB-Lite load/store master: FSM states,
// HTRANS/HSIZE codes, funct3 access codes and the alignment helper.
package mem_if_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        ERR   = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic misaligned_addr(input logic [1:0] size, input logic [2:0] low);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = low[0];
            2'b10:   bad = |low[1:0];
            2'b11:   bad = |low;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: replicates store data across the bus word and
// extracts/extends load data from the addressed lane.
module mem_lane_align
    import mem_if_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              wr_data,
    input  logic [1:0]                   wr_size,
    output logic [XLEN-1:0]              wr_lanes,
    input  logic [XLEN-1:0]              rd_data,
    input  logic [$clog2(XLEN/8)-1:0]    rd_lane,
    input  logic [1:0]                   rd_size,
    input  logic                         rd_unsigned,
    output logic [XLEN-1:0]              rd_result
);

    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] keep_s;
    logic            sign_s;
    logic            fill_s;

    // Replicate the right-justified store data so every lane of that size carries it.
    always_comb begin
        wr_lanes = wr_data;
        case (wr_size)
            2'b00:   wr_lanes = {(XLEN/8){wr_data[7:0]}};
            2'b01:   wr_lanes = {(XLEN/16){wr_data[15:0]}};
            2'b10:   wr_lanes = {(XLEN/32){wr_data[31:0]}};
            2'b11:   wr_lanes = wr_data;
            default: wr_lanes = wr_data;
        endcase
    end

    // Mask-based extension avoids zero-width replications when size equals XLEN.
    always_comb begin
        shifted_s = rd_data >> {rd_lane, 3'b000};
        keep_s    = {XLEN{1'b1}};
        sign_s    = shifted_s[XLEN-1];
        case (rd_size)
            2'b00: begin
                keep_s = XLEN'(8'hFF);
                sign_s = shifted_s[7];
            end
            2'b01: begin
                keep_s = XLEN'(16'hFFFF);
                sign_s = shifted_s[15];
            end
            2'b10: begin
                keep_s = XLEN'(32'hFFFF_FFFF);
                sign_s = shifted_s[31];
            end
            2'b11: begin
                keep_s = {XLEN{1'b1}};
                sign_s = shifted_s[XLEN-1];
            end
            default: begin
                keep_s = {XLEN{1'b1}};
                sign_s = shifted_s[XLEN-1];
            end
        endcase
        fill_s    = ~rd_unsigned & sign_s;
        rd_result = (shifted_s & keep_s) | (~keep_s & {XLEN{fill_s}});
    end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite master for the load/store unit: one transfer in flight, lane steering,
// wait states, two-cycle error responses. Optional data-phase timeout: AHB_TIMEOUT_EN.
module ahb_lite_master
    import mem_if_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter logic [3:0] HPROT_VALUE = 4'b0011,
    parameter int         TIMEOUT_CYC = 256
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_transfer,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    input  logic            cpu_write,
    input  logic            mem_mode,
    input  logic [2:0]      mem_function,
    output logic [XLEN-1:0] rdata,
    output logic            operation_complete,
    output logic            resp_valid,
    output logic            access_fault,
    output logic            misaligned,
    output logic [XLEN-1:0] haddr,
    output logic            hwrite,
    output logic [2:0]      hsize,
    output logic [2:0]      hburst,
    output logic [3:0]      hprot,
    output logic            hmastlock,
    output logic [1:0]      htrans,
    output logic            hsel,
    output logic [XLEN-1:0] hwdata,
    input  logic [XLEN-1:0] hrdata,
    input  logic            hreadyout,
    input  logic            hresp
);

    localparam int LANE_W = $clog2(XLEN/8);
    localparam logic [1:0] FULL_SIZE = (XLEN == 64) ? 2'b11 : 2'b10;

    state_t            state_r;
    logic [1:0]        size_r;
    logic              unsigned_r;
    logic [LANE_W-1:0] lane_r;
    logic [XLEN-1:0]   wdata_r;
    logic [XLEN-1:0]   haddr_r;
    logic              hwrite_r;
    logic [2:0]        hsize_r;
    logic [1:0]        htrans_r;
    logic              hsel_r;
    logic [XLEN-1:0]   hwdata_r;
    logic [XLEN-1:0]   rdata_r;
    logic              resp_valid_r;
    logic              access_fault_r;
    logic              misaligned_r;
    logic              op_complete_r;

    logic [1:0]        req_size_s;
    logic              req_unsigned_s;
    logic              illegal_s;
    logic              bad_req_s;
    logic [XLEN-1:0]   wdata_rep_s;
    logic [XLEN-1:0]   rdata_ext_s;
    logic              timeout_s;

    // Decode the incoming request: access size, extension and legality.
    always_comb begin
        req_size_s     = FULL_SIZE;
        req_unsigned_s = 1'b0;
        illegal_s      = 1'b0;
        if (mem_mode) begin
            req_size_s     = mem_function[1:0];
            req_unsigned_s = mem_function[2];
            illegal_s      = (mem_function == F3_BAD) ||
                             ((XLEN == 32) && ((mem_function == F3_D) || (mem_function == F3_WU)));
        end else begin
            req_size_s     = FULL_SIZE;
            req_unsigned_s = 1'b0;
            illegal_s      = 1'b0;
        end
        bad_req_s = illegal_s | misaligned_addr(req_size_s, cpu_addr[2:0]);
    end

    mem_lane_align #(.XLEN(XLEN)) u_lane_align (
        .wr_data     (cpu_wdata),
        .wr_size     (req_size_s),
        .wr_lanes    (wdata_rep_s),
        .rd_data     (hrdata),
        .rd_lane     (lane_r),
        .rd_size     (size_r),
        .rd_unsigned (unsigned_r),
        .rd_result   (rdata_ext_s)
    );

`ifdef AHB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_r;
    logic            busy_s;

    // Bus-busy flag: any state that is waiting on the slave.
    always_comb begin
        busy_s    = (state_r == ADDR) || (state_r == DATA) || (state_r == ERR);
        timeout_s = busy_s && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));
    end

    // Cycles spent on the bus; idle states hold it at zero so ADDR entry starts fresh.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (busy_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end
`else
    // Without the watchdog the master waits on hreadyout indefinitely.
    always_comb begin
        timeout_s = 1'b0;
    end
`endif

    // Transfer sequencer; every core- and bus-facing output is a register set here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            size_r         <= 2'b10;
            unsigned_r     <= 1'b0;
            lane_r         <= {LANE_W{1'b0}};
            wdata_r        <= {XLEN{1'b0}};
            haddr_r        <= {XLEN{1'b0}};
            hwrite_r       <= 1'b0;
            hsize_r        <= HSIZE_WORD;
            htrans_r       <= HTRANS_IDLE;
            hsel_r         <= 1'b0;
            hwdata_r       <= {XLEN{1'b0}};
            rdata_r        <= {XLEN{1'b0}};
            resp_valid_r   <= 1'b0;
            access_fault_r <= 1'b0;
            misaligned_r   <= 1'b0;
            op_complete_r  <= 1'b1;
        end else begin
            resp_valid_r <= 1'b0;
            if (timeout_s) begin
                state_r        <= FAULT;
                hsel_r         <= 1'b0;
                htrans_r       <= HTRANS_IDLE;
                access_fault_r <= 1'b1;
                resp_valid_r   <= 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (mem_transfer) begin
                            access_fault_r <= 1'b0;
                            misaligned_r   <= bad_req_s;
                            op_complete_r  <= 1'b0;
                            if (bad_req_s) begin
                                // Rejected before the bus sees anything.
                                state_r      <= FAULT;
                                resp_valid_r <= 1'b1;
                            end else begin
                                state_r    <= ADDR;
                                size_r     <= req_size_s;
                                unsigned_r <= req_unsigned_s;
                                lane_r     <= cpu_addr[LANE_W-1:0];
                                wdata_r    <= wdata_rep_s;
                                haddr_r    <= cpu_addr;
                                hwrite_r   <= cpu_write;
                                hsize_r    <= {1'b0, req_size_s};
                                hsel_r     <= 1'b1;
                                htrans_r   <= HTRANS_NONSEQ;
                            end
                        end
                    end
                    ADDR: begin
                        if (hreadyout) begin
                            state_r  <= DATA;
                            htrans_r <= HTRANS_IDLE;
                            hwdata_r <= wdata_r;
                        end
                    end
                    DATA: begin
                        if (hresp) begin
                            state_r <= ERR;
                        end else if (hreadyout) begin
                            state_r      <= DONE;
                            hsel_r       <= 1'b0;
                            resp_valid_r <= 1'b1;
                            if (!hwrite_r) begin
                                rdata_r <= rdata_ext_s;
                            end
                        end
                    end
                    ERR: begin
                        if (hreadyout) begin
                            state_r        <= FAULT;
                            hsel_r         <= 1'b0;
                            access_fault_r <= 1'b1;
                            resp_valid_r   <= 1'b1;
                        end
                    end
                    DONE, FAULT: begin
                        state_r       <= IDLE;
                        op_complete_r <= 1'b1;
                    end
                    default: begin
                        state_r       <= IDLE;
                        hsel_r        <= 1'b0;
                        htrans_r      <= HTRANS_IDLE;
                        op_complete_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rdata              = rdata_r;
    assign operation_complete = op_complete_r;
    assign resp_valid         = resp_valid_r;
    assign access_fault       = access_fault_r;
    assign misaligned         = misaligned_r;
    assign haddr              = haddr_r;
    assign hwrite             = hwrite_r;
    assign hsize              = hsize_r;
    assign hburst             = 3'b000;
    assign hprot              = HPROT_VALUE;
    assign hmastlock          = 1'b0;
    assign htrans             = htrans_r;
    assign hsel               = hsel_r;
    assign hwdata             = hwdata_r;

endmodule
